// File: rtl/spi_framer_pkg.sv
// Shared definitions for the SPI framer: FSM state encoding and header byte layout.
package spi_framer_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HEAD = 2'd1,
    ST_LEN  = 2'd2,
    ST_BODY = 2'd3
  } state_t;

  // Header byte: bits 7:1 carry the fixed tag, bit 0 says another chunk of this packet follows.
  function automatic logic [7:0] header_byte(input logic [6:0] hdr, input logic more);
    return {hdr, more};
  endfunction

endpackage

// File: rtl/spi_frame_ram.sv
// Payload buffer for the framer: one synchronous write port and one combinational read port.
module spi_frame_ram #(
  parameter int ABITS = 4
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [ABITS-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [2**ABITS];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_framer.sv
// Buffers an AXI-S byte packet in chunks of up to DEPTH bytes and re-emits each chunk
// as a frame: header byte, length byte, then the payload.
module spi_framer
  import spi_framer_pkg::*;
#(
  parameter logic [6:0] HEADER = 7'h23,
  parameter int         ABITS  = 4
) (
  input  logic        clock,
  input  logic        aresetn,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [7:0]  s_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [7:0]  m_tdata,
  output logic        busy_o,
  output logic [15:0] frames_o
);

  localparam int            DEPTH   = 1 << ABITS;
  localparam int            CW      = ABITS + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic             more, more_next;
  logic [ABITS-1:0] idx, idx_next;
  logic             s_tready_next;
  logic             m_tvalid_next, m_tlast_next;
  logic [7:0]       m_tdata_next;
  logic [15:0]      frame_count, frame_count_next;
  logic             in_fire, out_fire;
  logic [ABITS-1:0] rd_addr;
  logic [7:0]       rd_data;

  assign in_fire  = (state == ST_FILL) && s_tvalid && s_tready;
  assign out_fire = m_tvalid && m_tready;
  // Read one byte ahead so the next output byte is ready to load on the current handshake.
  assign rd_addr  = (state == ST_BODY) ? idx + ABITS'(1) : '0;

  spi_frame_ram #(.ABITS(ABITS)) u_ram (
    .clock   (clock),
    .wr_en   (in_fire),
    .wr_addr (count[ABITS-1:0]),
    .wr_data (s_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_FILL;
      count       <= '0;
      more        <= 1'b0;
      idx         <= '0;
      s_tready    <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tdata     <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      more        <= more_next;
      idx         <= idx_next;
      s_tready    <= s_tready_next;
      m_tvalid    <= m_tvalid_next;
      m_tlast     <= m_tlast_next;
      m_tdata     <= m_tdata_next;
      frame_count <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    count_next       = count;
    more_next        = more;
    idx_next         = idx;
    s_tready_next    = s_tready;
    m_tvalid_next    = m_tvalid;
    m_tlast_next     = m_tlast;
    m_tdata_next     = m_tdata;
    frame_count_next = frame_count;
    case (state)
      ST_FILL: begin
        s_tready_next = 1'b1;
        if (in_fire) begin
          count_next = count + ONE;
          if (s_tlast || (count == FULL_M1)) begin
            more_next     = ~s_tlast;
            state_next    = ST_HEAD;
            s_tready_next = 1'b0;
            m_tvalid_next = 1'b1;
            m_tlast_next  = 1'b0;
            m_tdata_next  = header_byte(HEADER, more_next);
          end
        end
      end
      ST_HEAD: begin
        if (out_fire) begin
          m_tdata_next = 8'(count);
          state_next   = ST_LEN;
        end
      end
      ST_LEN: begin
        if (out_fire) begin
          m_tdata_next = rd_data;
          m_tlast_next = (count == ONE);
          idx_next     = '0;
          state_next   = ST_BODY;
        end
      end
      ST_BODY: begin
        if (out_fire) begin
          if (m_tlast) begin
            state_next       = ST_FILL;
            count_next       = '0;
            more_next        = 1'b0;
            s_tready_next    = 1'b1;
            m_tvalid_next    = 1'b0;
            m_tlast_next     = 1'b0;
            m_tdata_next     = '0;
            frame_count_next = frame_count + 16'd1;
          end else begin
            idx_next     = idx + ABITS'(1);
            m_tdata_next = rd_data;
            m_tlast_next = (({1'b0, idx} + CW'(2)) == count);
          end
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  assign busy_o   = (state != ST_FILL) || (count != '0);
  assign frames_o = frame_count;

endmodule

// File: tb/tb_spi_framer.sv
// Self-checking bench for spi_framer: directed frames, random packets with backpressure,
// mid-frame reset and frame counter wrap, scored against a packet-level framing model.
module tb_spi_framer;

  localparam int         DEPTH = 16;
  localparam logic [6:0] HDR   = 7'h23;

  logic        clock    = 1'b0;
  logic        aresetn  = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast  = 1'b0;
  logic [7:0]  s_tdata  = 8'h00;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [7:0]  m_tdata;
  logic        busy_o;
  logic [15:0] frames_o;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          rx_count     = 0;
  logic [7:0]  tx_q[$];
  logic [8:0]  exp_q[$];
  logic [15:0] frames_exp   = 16'h0000;
  bit          rand_ready   = 1'b0;
  bit          forced_ready = 1'b1;
  logic        prev_stall   = 1'b0;
  logic [8:0]  prev_beat    = 9'h000;

  spi_framer dut (
    .clock    (clock),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .busy_o   (busy_o),
    .frames_o (frames_o)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Output beats are compared in order; a stalled beat must be unchanged on the next cycle.
  always @(negedge clock) begin
    if (aresetn && prev_stall)
      checkOutput("stall_hold", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, prev_beat});
    if (aresetn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) checkOutput("unexpected_beat", exp_q.size(), 1);
      else checkOutput("beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_q.pop_front()});
      rx_count++;
    end
    prev_stall = aresetn && m_tvalid && !m_tready;
    prev_beat  = {m_tlast, m_tdata};
  end

  task automatic buildExpected();
    int n   = tx_q.size();
    int off = 0;
    while (off < n) begin
      int len  = ((n - off) > DEPTH) ? DEPTH : (n - off);
      bit more = ((n - off) > DEPTH);
      exp_q.push_back({1'b0, HDR, more});
      exp_q.push_back({1'b0, 8'(len)});
      for (int j = 0; j < len; j++) exp_q.push_back({1'(j == len - 1), tx_q[off + j]});
      frames_exp++;
      off += len;
    end
  endtask

  // Called aligned just after a rising edge; returns just after the last input handshake.
  task automatic applyStimulus(input bit gaps);
    buildExpected();
    for (int i = 0; i < tx_q.size(); i++) begin
      int t = 0;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clock); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = tx_q[i];
      s_tlast  = (i == tx_q.size() - 1);
      do begin @(negedge clock); t++; end while (!s_tready && t < 5000);
      if (!s_tready) begin
        checkOutput("s_tready_timeout", 32'(s_tready), 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int t = 0;
    do begin @(negedge clock); #1; t++; end while ((exp_q.size() != 0 || busy_o) && t < 5000);
    checkOutput({tag, "_drained"}, exp_q.size(), 0);
    checkOutput({tag, "_frames"}, 32'(frames_o), 32'(frames_exp));
    @(posedge clock); #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int t;
    #2;
    checkOutput("rst_m_tvalid", 32'(m_tvalid), 0);
    checkOutput("rst_m_tlast", 32'(m_tlast), 0);
    checkOutput("rst_m_tdata", 32'(m_tdata), 0);
    checkOutput("rst_s_tready", 32'(s_tready), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_frames", 32'(frames_o), 0);
    @(negedge clock); #1;
    aresetn = 1'b1;
    #1;
    checkOutput("s_tready_before_edge", 32'(s_tready), 0);
    @(posedge clock); #1;
    checkOutput("s_tready_after_edge", 32'(s_tready), 1);

    // Three-byte packet, full-rate output, header the cycle after close.
    tx_q = '{8'h11, 8'h22, 8'h33};
    applyStimulus(1'b0);
    checkOutput("head_valid", 32'(m_tvalid), 1);
    checkOutput("busy_after_close", 32'(busy_o), 1);
    checkOutput("s_tready_closed", 32'(s_tready), 0);
    base = rx_count;
    repeat (5) @(negedge clock);
    #1;
    checkOutput("no_bubble", rx_count - base, 5);
    waitIdle("short");

    tx_q.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i));
    applyStimulus(1'b0);
    waitIdle("split20");

    tx_q.delete();
    for (int i = 0; i < DEPTH; i++) tx_q.push_back(8'(8'hC0 + i));
    applyStimulus(1'b0);
    waitIdle("exact16");

    @(negedge clock);
    rand_ready = 1'b1;
    @(posedge clock); #1;
    for (int p = 0; p < 100; p++) begin
      int n = $urandom_range(1, 40);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      applyStimulus(1'($urandom_range(0, 1)));
    end
    waitIdle("random");
    @(negedge clock);
    rand_ready   = 1'b0;
    forced_ready = 1'b0;
    @(posedge clock); #1;

    // Reset while a body byte is stalled on the output.
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    applyStimulus(1'b0);
    base = rx_count;
    @(negedge clock);
    forced_ready = 1'b1;
    t = 0;
    while (rx_count < base + 3 && t < 100) begin @(negedge clock); #1; t++; end
    forced_ready = 1'b0;
    checkOutput("reach_body", rx_count - base, 3);
    @(posedge clock); #3;
    checkOutput("body_valid_before_reset", 32'(m_tvalid), 1);
    aresetn = 1'b0;
    #1;
    checkOutput("async_m_tvalid", 32'(m_tvalid), 0);
    checkOutput("async_m_tlast", 32'(m_tlast), 0);
    checkOutput("async_s_tready", 32'(s_tready), 0);
    checkOutput("async_busy", 32'(busy_o), 0);
    checkOutput("async_frames", 32'(frames_o), 0);
    exp_q.delete();
    frames_exp = 16'h0000;
    @(negedge clock);
    @(negedge clock); #1;
    aresetn = 1'b1;
    #1;
    checkOutput("rerelease_s_tready_low", 32'(s_tready), 0);
    forced_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput("rerelease_s_tready_high", 32'(s_tready), 1);
    tx_q = '{8'hAA};
    applyStimulus(1'b0);
    waitIdle("after_reset");

    // Jump the frame counter to its top value, then one more frame wraps it.
    force dut.frame_count = 16'hFFFF;
    @(negedge clock);
    release dut.frame_count;
    #1;
    checkOutput("frames_preload", 32'(frames_o), 32'h0000FFFF);
    frames_exp = 16'hFFFF;
    @(posedge clock); #1;
    tx_q = '{8'h5A};
    applyStimulus(1'b0);
    waitIdle("wrap");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_framer.md
SPI_FRAMER -- requirements
Module: spi_framer

Interface
REQ-001 Parameter HEADER, default 7'h23: upper seven bits of every frame header byte.
REQ-002 Parameter ABITS, default 4: payload buffer address width; DEPTH = 2**ABITS bytes (16).
REQ-003 Port clock  input  1: single clock; all logic on rising edge.
REQ-004 Port aresetn  input  1: one clock; reset is asynchronous and active-low.
REQ-005 Port s_tvalid/s_tready/s_tlast  input/output/input  1 each: upstream AXI-S byte-packet handshake.
REQ-006 Port s_tdata  input  8: upstream payload byte.
REQ-007 Port m_tvalid/m_tready/m_tlast  output/input/output  1 each: framed stream toward the SPI master transmit FIFO.
REQ-008 Port m_tdata  output  8: framed byte.
REQ-009 Port busy_o  output  1: high whenever state is not ST_FILL or the buffer is non-empty.
REQ-010 Port frames_o  output  16: count of frames fully emitted, wraps modulo 2**16.

Function
REQ-011 FSM states ST_FILL, ST_HEAD, ST_LEN, ST_BODY; only ST_FILL accepts input, only the others drive m_tvalid.
REQ-012 ST_FILL: s_tready = 1 while count < DEPTH; each accepted byte is written at buffer[count], count increments.
REQ-013 Chunk closes on an accepted byte with s_tlast=1 or with count reaching DEPTH; next state ST_HEAD.
REQ-014 more flag latched at chunk close = 1 if closed by full buffer with s_tlast=0, else 0.
REQ-015 ST_HEAD: m_tdata = {HEADER, more}, m_tlast=0; advance to ST_LEN on m_tvalid & m_tready.
REQ-016 ST_LEN: m_tdata = count (1..DEPTH, eight bits; 16 encodes as 8'h10), m_tlast=0; advance to ST_BODY on handshake.
REQ-017 ST_BODY: emit buffer[0..count-1] in order; m_tlast=1 on index count-1 only; after its handshake count clears, frames_o increments, state returns to ST_FILL.
REQ-018 Header byte appears on m_tvalid the cycle after the closing input handshake; no bubbles between header, length and body while m_tready=1.
REQ-019 m_tvalid, m_tdata and m_tlast are registered and held stable while m_tvalid=1 and m_tready=0.
REQ-020 s_tready = 0 in all states other than ST_FILL; no input/output overlap (single buffer).
REQ-021 Zero-length frames are never emitted; an input packet longer than DEPTH is split into DEPTH-byte chunks with more=1, last chunk more=0.
REQ-022 Packet of exactly DEPTH bytes with tlast on byte DEPTH yields one frame, more=0.

Reset
REQ-023 On aresetn low, immediately: state ST_FILL, count 0, more 0, m_tvalid 0, m_tlast 0, m_tdata 0, s_tready 0, frames_o 0, busy_o 0.
REQ-024 Reset mid-frame discards buffered data and any partially sent frame; no resume.
REQ-025 s_tready rises only on the first rising clock edge after aresetn deasserts.

Structure
REQ-026 State encodings and the header-byte layout (HEADER bits 7:1, more bit 0) are defined in shared package spi_framer_pkg.
REQ-027 Payload storage is sub-module spi_frame_ram: DEPTH x 8, one synchronous write port and one read port, no reset on contents.

Verification
REQ-028 Send 11,22,33 (tlast on 33) -> out 46,03,11,22,33 (hex), m_tlast on 33, frames_o=1.
REQ-029 Send 20 bytes 00..13, tlast on 13 -> 47,10,00..0F (tlast on 0F), then 46,04,10..13 (tlast on 13); frames_o=2.
REQ-030 Send 16 bytes, tlast on 16th -> single frame 46,10,+16 bytes; no second frame.
REQ-031 Random m_tready backpressure (50%) over 100 random packets -> scoreboard matches framed reference model, outputs stable while stalled.
REQ-032 Assert aresetn low during ST_BODY -> m_tvalid 0 asynchronously; after release s_tready=1, next 1-byte packet AA -> 46,01,AA.
REQ-033 Preload frames_o to FFFF by 65535 1-byte packets (accelerated) -> next frame wraps frames_o to 0000.
